// File: rtl/video_timing_sched.sv
// video_timing_sched: frame-boundary scheduler for resolution/pattern changes with settle reset and auto pattern cycling
module video_timing_sched #(
    parameter int FRAMES_PER_PATTERN = 256,
    parameter int SETTLE_CYCLES      = 16,
    parameter int VS_TIMEOUT         = 1_000_000,
    parameter bit AUTO_CYCLE         = 1'b1
) (
    input  logic        I_pxl_clk,
    input  logic        I_rst_n,
    input  logic        I_vs,
    input  logic        I_req,
    input  logic [1:0]  I_req_res,
    input  logic [2:0]  I_req_mode,
    output logic        O_busy,
    output logic        O_ack,
    output logic        O_err,
    output logic        O_tp_rst_n,
    output logic [2:0]  O_mode,
    output logic [15:0] O_h_total,
    output logic [15:0] O_h_sync,
    output logic [15:0] O_h_bporch,
    output logic [15:0] O_h_res,
    output logic [15:0] O_v_total,
    output logic [15:0] O_v_sync,
    output logic [15:0] O_v_bporch,
    output logic [15:0] O_v_res,
    output logic        O_hs_pol,
    output logic        O_vs_pol
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT_VS, S_HOLD, S_RELEASE} state_t;

    state_t       r_state, w_next;
    logic         r_vs, r_pend, r_tp_rst_n, r_ack, r_err;
    logic [1:0]   r_res, r_req_res;
    logic [2:0]   r_mode, r_req_mode;
    logic [31:0]  r_cnt, r_frame;
    logic [129:0] r_tim;
    logic         w_vs_fall, w_bad, w_change, w_idle, w_accept, w_reject;
    logic         w_apply, w_settled, w_release, w_frame_tick, w_wrap;

    function automatic logic [129:0] f_tim(input logic [1:0] res);
        return res == 2'd1 ? {16'd1344, 16'd136, 16'd160, 16'd1024, 16'd806, 16'd6, 16'd29, 16'd768, 2'b00} :
               res == 2'd2 ? {16'd1650, 16'd40,  16'd220, 16'd1280, 16'd750, 16'd5, 16'd20, 16'd720, 2'b11} :
                             {16'd1056, 16'd128, 16'd88,  16'd800,  16'd628, 16'd4, 16'd23, 16'd600, 2'b11};
    endfunction

    assign w_vs_fall = r_vs & ~I_vs;
    assign w_bad     = (I_req_res == 2'd3) || (I_req_mode > 3'd4);
    assign w_change  = r_req_res != r_res;

    always_ff @(posedge I_pxl_clk) begin
        r_state <= !I_rst_n ? S_HOLD : w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    w_next = w_accept ? S_WAIT_VS : S_IDLE;
            S_WAIT_VS: w_next = !w_apply ? S_WAIT_VS : w_change ? S_HOLD : S_IDLE;
            S_HOLD:    w_next = w_settled ? S_RELEASE : S_HOLD;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_idle       = r_state == S_IDLE;
        O_busy       = !w_idle;
        w_accept     = w_idle & I_req & ~w_bad;
        w_reject     = w_idle & I_req & w_bad;
        w_apply      = (r_state == S_WAIT_VS) && (w_vs_fall || r_cnt == 32'(VS_TIMEOUT - 1));
        w_settled    = (r_state == S_HOLD) && r_cnt == 32'(SETTLE_CYCLES - 1);
        w_release    = r_state == S_RELEASE;
        w_frame_tick = AUTO_CYCLE && w_idle && w_vs_fall;
        w_wrap       = w_frame_tick && r_frame == 32'(FRAMES_PER_PATTERN - 1);
    end

    // r_cnt serves as timeout counter in WAIT_VS and settle counter in HOLD
    always_ff @(posedge I_pxl_clk) begin
        if (!I_rst_n) begin
            r_vs       <= 1'b0;
            r_cnt      <= '0;
            r_frame    <= '0;
            r_pend     <= 1'b0;
            r_res      <= 2'd0;
            r_req_res  <= 2'd0;
            r_req_mode <= 3'd0;
            r_mode     <= 3'd0;
            r_tp_rst_n <= 1'b0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_tim      <= f_tim(2'd0);
        end else begin
            r_vs  <= I_vs;
            r_cnt <= (w_next != r_state) ? '0 : r_cnt + 32'd1;
            r_ack <= (w_apply & ~w_change) | (w_release & r_pend);
            r_err <= w_reject;
            if (w_accept) begin
                r_req_res  <= I_req_res;
                r_req_mode <= I_req_mode;
                r_pend     <= 1'b1;
            end
            if (w_frame_tick) r_frame <= w_wrap ? '0 : r_frame + 32'd1;
            if (w_wrap && !w_accept) r_mode <= (r_mode == 3'd4) ? 3'd0 : r_mode + 3'd1;
            if (w_apply) begin
                r_frame <= '0;
                r_mode  <= r_req_mode;
            end
            if (w_apply & w_change) begin
                r_res      <= r_req_res;
                r_tim      <= f_tim(r_req_res);
                r_tp_rst_n <= 1'b0;
            end
            if ((w_apply & ~w_change) | w_release) r_pend <= 1'b0;
            if (w_release) r_tp_rst_n <= 1'b1;
        end
    end

    assign O_ack      = r_ack;
    assign O_err      = r_err;
    assign O_tp_rst_n = r_tp_rst_n;
    assign O_mode     = r_mode;
    assign {O_h_total, O_h_sync, O_h_bporch, O_h_res, O_v_total, O_v_sync, O_v_bporch, O_v_res, O_hs_pol, O_vs_pol} = r_tim;
endmodule

// File: tb/tb_video_timing_sched.sv
// tb_video_timing_sched: table-driven requests, corner sequences and random traffic against a frame-level reference model
module tb_video_timing_sched;
    localparam int FPP    = 4;
    localparam int SETTLE = 16;
    localparam int VS_TO  = 100;

    logic        I_pxl_clk, I_rst_n, I_vs, I_req;
    logic [1:0]  I_req_res;
    logic [2:0]  I_req_mode;
    logic        O_busy, O_ack, O_err, O_tp_rst_n, O_hs_pol, O_vs_pol;
    logic [2:0]  O_mode;
    logic [15:0] O_h_total, O_h_sync, O_h_bporch, O_h_res, O_v_total, O_v_sync, O_v_bporch, O_v_res;

    video_timing_sched #(.FRAMES_PER_PATTERN(FPP), .SETTLE_CYCLES(SETTLE), .VS_TIMEOUT(VS_TO), .AUTO_CYCLE(1'b1)) dut (
        .I_pxl_clk(I_pxl_clk), .I_rst_n(I_rst_n), .I_vs(I_vs), .I_req(I_req),
        .I_req_res(I_req_res), .I_req_mode(I_req_mode),
        .O_busy(O_busy), .O_ack(O_ack), .O_err(O_err), .O_tp_rst_n(O_tp_rst_n), .O_mode(O_mode),
        .O_h_total(O_h_total), .O_h_sync(O_h_sync), .O_h_bporch(O_h_bporch), .O_h_res(O_h_res),
        .O_v_total(O_v_total), .O_v_sync(O_v_sync), .O_v_bporch(O_v_bporch), .O_v_res(O_v_res),
        .O_hs_pol(O_hs_pol), .O_vs_pol(O_vs_pol)
    );

    initial I_pxl_clk = 1'b0;
    always #5 I_pxl_clk = ~I_pxl_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [129:0] tim_tab(input int r);
        case (r)
            1:       return {16'd1344, 16'd136, 16'd160, 16'd1024, 16'd806, 16'd6, 16'd29, 16'd768, 2'b00};
            2:       return {16'd1650, 16'd40,  16'd220, 16'd1280, 16'd750, 16'd5, 16'd20, 16'd720, 2'b11};
            default: return {16'd1056, 16'd128, 16'd88,  16'd800,  16'd628, 16'd4, 16'd23, 16'd600, 2'b11};
        endcase
    endfunction

    // Reference: a request waits for a frame end (or timeout), then either swaps the mode
    // immediately or drops the pixel reset for the settle window plus one release cycle.
    bit m_valid = 0;
    bit m_wait, m_pend, m_vs_prev, m_tp, m_ack, m_err;
    int m_hold_left, m_wait_cnt, m_frame, m_res, m_mode, m_rq_res, m_rq_mode;

    always @(posedge I_pxl_clk) begin
        bit vf, acc;
        vf = m_vs_prev && !I_vs;
        m_vs_prev = I_vs;
        m_ack = 0;
        m_err = 0;
        if (!I_rst_n) begin
            m_valid = 1; m_hold_left = SETTLE + 1; m_wait = 0; m_pend = 0;
            m_res = 0; m_mode = 0; m_tp = 0; m_frame = 0; m_vs_prev = 0;
        end else if (m_hold_left > 0) begin
            m_hold_left--;
            if (m_hold_left == 0) begin
                m_tp = 1; m_ack = m_pend; m_pend = 0;
            end
        end else if (m_wait) begin
            m_wait_cnt++;
            if (vf || m_wait_cnt == VS_TO) begin
                m_wait = 0; m_frame = 0; m_mode = m_rq_mode;
                if (m_rq_res != m_res) begin
                    m_res = m_rq_res; m_tp = 0; m_hold_left = SETTLE + 1;
                end else begin
                    m_ack = 1; m_pend = 0;
                end
            end
        end else begin
            acc = I_req && I_req_res != 2'd3 && I_req_mode <= 3'd4;
            if (I_req && !acc) m_err = 1;
            if (acc) begin
                m_rq_res = int'(I_req_res); m_rq_mode = int'(I_req_mode);
                m_pend = 1; m_wait = 1; m_wait_cnt = 0;
            end
            if (vf) begin
                m_frame = (m_frame + 1) % FPP;
                if (m_frame == 0 && !acc) m_mode = (m_mode + 1) % 5;
            end
        end
    end

    logic [136:0] act_v, exp_v;
    always @(negedge I_pxl_clk) begin
        if (m_valid) begin
            act_v = {O_busy, O_ack, O_err, O_tp_rst_n, O_mode, O_h_total, O_h_sync, O_h_bporch, O_h_res,
                     O_v_total, O_v_sync, O_v_bporch, O_v_res, O_hs_pol, O_vs_pol};
            exp_v = {(m_wait || m_hold_left > 0), m_ack, m_err, m_tp, 3'(m_mode), tim_tab(m_res)};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL model t=%0t got %h expected %h", $time, act_v, exp_v);
            end
        end
    end

    int  s_errs, s_acks;
    bit  s_drop;

    task automatic mon();
        @(negedge I_pxl_clk);
        s_errs += int'(O_err);
        s_acks += int'(O_ack);
        if (!O_tp_rst_n) s_drop = 1;
    endtask

    task automatic vs_pulse();
        I_vs = 1'b1;
        repeat (3) mon();
        I_vs = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (O_busy && n < 300) begin
            mon();
            n++;
        end
        if (n >= 300) chk({nm, "_timeout"}, 1, 0);
    endtask

    task automatic do_req(input logic [1:0] res, input logic [2:0] mode, input bit spam);
        s_errs = 0; s_acks = 0; s_drop = 0;
        @(negedge I_pxl_clk);
        I_req = 1'b1; I_req_res = res; I_req_mode = mode;
        mon();
        I_req = spam; I_req_res = 2'd3;
        if (O_busy) begin
            repeat (5) mon();
            I_req = 1'b0;
            vs_pulse();
            wait_idle("req");
        end
        I_req = 1'b0;
        repeat (3) mon();
    endtask

    typedef struct {
        logic [1:0] res;
        logic [2:0] mode;
        int err;
        int drop;
        int h_total;
        int v_res;
        int mode_o;
    } vec_t;
    vec_t tbl[7];

    int n, lows, ph, per;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{2'd2, 3'd1, 0, 1, 1650, 720, 1};
        tbl[1] = '{2'd2, 3'd3, 0, 0, 1650, 720, 3};
        tbl[2] = '{2'd3, 3'd0, 1, 0, 1650, 720, 3};
        tbl[3] = '{2'd1, 3'd5, 1, 0, 1650, 720, 3};
        tbl[4] = '{2'd1, 3'd4, 0, 1, 1344, 768, 4};
        tbl[5] = '{2'd0, 3'd0, 0, 1, 1056, 600, 0};
        tbl[6] = '{2'd0, 3'd2, 0, 0, 1056, 600, 2};

        I_rst_n = 1'b0; I_vs = 1'b0; I_req = 1'b0; I_req_res = 2'd0; I_req_mode = 3'd0;
        repeat (3) @(posedge I_pxl_clk);
        @(negedge I_pxl_clk);
        I_rst_n = 1'b1;
        lows = 0; s_acks = 0; s_errs = 0;
        repeat (30) begin
            mon();
            lows += int'(!O_tp_rst_n);
        end
        chk("reset_low_cycles", lows, SETTLE);
        chk("reset_no_ack", s_acks, 0);
        chk("reset_h_total", int'(O_h_total), 1056);
        chk("reset_mode", int'(O_mode), 0);
        chk("reset_busy", int'(O_busy), 0);

        for (int i = 0; i < 7; i++) begin
            do_req(tbl[i].res, tbl[i].mode, 1'b0);
            chk($sformatf("tbl%0d_err", i), s_errs, tbl[i].err);
            chk($sformatf("tbl%0d_ack", i), s_acks, 1 - tbl[i].err);
            chk($sformatf("tbl%0d_drop", i), int'(s_drop), tbl[i].drop);
            chk($sformatf("tbl%0d_h_total", i), int'(O_h_total), tbl[i].h_total);
            chk($sformatf("tbl%0d_v_res", i), int'(O_v_res), tbl[i].v_res);
            chk($sformatf("tbl%0d_mode", i), int'(O_mode), tbl[i].mode_o);
        end

        do_req(2'd1, 3'd1, 1'b1);
        chk("busy_ignore_err", s_errs, 0);
        chk("busy_ignore_ack", s_acks, 1);
        chk("busy_ignore_h_total", int'(O_h_total), 1344);
        chk("busy_ignore_mode", int'(O_mode), 1);

        for (int k = 1; k <= 20; k++) begin
            @(negedge I_pxl_clk);
            vs_pulse();
            repeat (2) mon();
            chk($sformatf("auto_mode_%0d", k), int'(O_mode), (1 + k / FPP) % 5);
        end
        repeat (3) begin
            @(negedge I_pxl_clk);
            vs_pulse();
            repeat (2) mon();
        end
        @(negedge I_pxl_clk);
        I_vs = 1'b1;
        repeat (2) @(negedge I_pxl_clk);
        I_vs = 1'b0; I_req = 1'b1; I_req_res = 2'd1; I_req_mode = 3'd3;
        @(negedge I_pxl_clk);
        I_req = 1'b0;
        chk("coincide_no_advance", int'(O_mode), 1);
        chk("coincide_busy", int'(O_busy), 1);
        vs_pulse();
        wait_idle("coincide");
        chk("coincide_mode", int'(O_mode), 3);

        @(negedge I_pxl_clk);
        I_req = 1'b1; I_req_res = 2'd2; I_req_mode = 3'd0;
        @(negedge I_pxl_clk);
        I_req = 1'b0;
        n = 0;
        while (O_tp_rst_n && n < 300) begin
            @(negedge I_pxl_clk);
            n++;
        end
        chk("timeout_cycles", n, VS_TO);
        chk("timeout_h_total", int'(O_h_total), 1650);
        repeat (5) @(negedge I_pxl_clk);
        I_rst_n = 1'b0;
        repeat (2) @(negedge I_pxl_clk);
        I_rst_n = 1'b1;
        lows = 0; s_acks = 0;
        repeat (30) begin
            mon();
            lows += int'(!O_tp_rst_n);
        end
        chk("abort_low_cycles", lows, SETTLE);
        chk("abort_no_ack", s_acks, 0);
        chk("abort_h_total", int'(O_h_total), 1056);
        chk("abort_v_res", int'(O_v_res), 600);
        chk("abort_mode", int'(O_mode), 0);

        ph = 0; per = 30;
        for (int c = 0; c < 4000; c++) begin
            @(negedge I_pxl_clk);
            I_rst_n    = $urandom_range(0, 999) != 0;
            I_req      = $urandom_range(0, 11) == 0;
            I_req_res  = 2'($urandom);
            I_req_mode = 3'($urandom);
            ph++;
            if (ph >= per) begin
                ph = 0;
                per = ($urandom_range(0, 7) == 0) ? $urandom_range(120, 250) : $urandom_range(15, 60);
            end
            I_vs = ph < 3;
        end
        @(negedge I_pxl_clk);
        I_req = 1'b0;
        repeat (2) @(negedge I_pxl_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
